// File: rtl/eight_three_priority_encoder.sv
// ---------------------------------------------------------------------------
// eight_three_priority_encoder
//
// Sequential 8-to-3 priority encoder with a valid/ack handshake.
// Each request line X[i] is accumulated into a pending register.
// The index of the highest-priority pending request is presented on O.
// O is held stable until the consumer acknowledges it. The acknowledged
// request is then retired and the next pending request is presented.
// O can drive the X input of the matching 3-to-8 decoder directly.
//
// Parameters
//   PRIO_HIGH : 1 = index 7 has the highest priority,
//               0 = index 0 has the highest priority.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   En    in   1  capture enable for X (draining continues while 0)
//   X     in   8  request lines, multi-hot allowed
//   Ack   in   1  consumer accepts the current code (only used while Valid=1)
//   O     out  3  registered index of the presented request
//   Valid out  1  registered, O holds a pending request
//   Pend  out  8  registered pending register
//   Lost  out  1  sticky, a request hit an already-pending, non-retiring bit
// ---------------------------------------------------------------------------
module eight_three_priority_encoder #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [7:0] X,
  input  logic       Ack,
  output logic [2:0] O,
  output logic       Valid,
  output logic [7:0] Pend,
  output logic       Lost
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [7:0] pend_reg;
  logic [2:0] o_reg;
  logic       valid_reg;
  logic       lost_reg;

  logic       retire;
  logic [7:0] clr_mask;
  logic [7:0] set_mask;
  logic [7:0] pend_next;
  logic [2:0] prio_idx;

  // A transfer happens only while a code is presented. Ack in IDLE is ignored.
  assign retire = (state_reg == PRESENT) && Ack;

  // One-hot clear of the bit currently shown on O.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_clr
      assign clr_mask[gi] = retire && (o_reg == 3'(gi));
    end
  endgenerate

  assign set_mask = En ? X : 8'h00;

  // Set wins over clear. A request on the retiring bit keeps it pending.
  assign pend_next = (pend_reg & ~clr_mask) | set_mask;

  // Priority pick over the current pending register.
  // The last matching bit in scan order wins.
  always_comb begin
    prio_idx = 3'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_reg[i]) prio_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_reg[i]) prio_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 8'h00;
      o_reg     <= 3'd0;
      valid_reg <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;

      // Only a collision on a bit that stays pending counts as a loss.
      if (|(set_mask & pend_reg & ~clr_mask)) begin
        lost_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          // Priority is decided here only. Later arrivals wait their turn.
          if (|pend_reg) begin
            o_reg     <= prio_idx;
            valid_reg <= 1'b1;
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          // O is frozen. Leaving via IDLE forces the one-cycle bubble.
          if (Ack) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign O     = o_reg;
  assign Valid = valid_reg;
  assign Pend  = pend_reg;
  assign Lost  = lost_reg;

endmodule

// File: tb/tb_eight_three_priority_encoder.sv
module tb_eight_three_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] x   = 8'h00;
  logic       ack = 1'b0;

  logic [2:0] o_hi, o_lo;
  logic       valid_hi, valid_lo;
  logic [7:0] pend_hi, pend_lo;
  logic       lost_hi, lost_lo;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  eight_three_priority_encoder #(.PRIO_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .En(en), .X(x), .Ack(ack),
    .O(o_hi), .Valid(valid_hi), .Pend(pend_hi), .Lost(lost_hi)
  );

  eight_three_priority_encoder #(.PRIO_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .En(en), .X(x), .Ack(ack),
    .O(o_lo), .Valid(valid_lo), .Pend(pend_lo), .Lost(lost_lo)
  );

  // Reference model. Index 1 models PRIO_HIGH=1 and index 0 models PRIO_HIGH=0.
  logic [7:0] m_pend[2];
  logic [2:0] m_o[2];
  logic       m_valid[2];
  logic       m_lost[2];

  // Highest set bit is floor(log2(p)). Lowest set bit is log2(p & -p).
  function automatic logic [2:0] pick(input logic [7:0] p, input bit high);
    int v;
    v = int'(p);
    if (high) return 3'($clog2(v + 1) - 1);
    else      return 3'($clog2(v & -v));
  endfunction

  // Advance the model by one edge using the current inputs, then wait for
  // that edge and let the outputs settle.
  task automatic step();
    logic [7:0] clr, set;
    for (int k = 0; k < 2; k++) begin
      clr = (m_valid[k] && ack) ? (8'h01 << m_o[k]) : 8'h00;
      set = en ? x : 8'h00;
      if (rst) begin
        m_pend[k] = 8'h00; m_o[k] = 3'd0; m_valid[k] = 1'b0; m_lost[k] = 1'b0;
      end else begin
        if ((set & m_pend[k] & ~clr) != 8'h00) m_lost[k] = 1'b1;
        if (!m_valid[k]) begin
          if (m_pend[k] != 8'h00) begin
            m_o[k] = pick(m_pend[k], k == 1);
            m_valid[k] = 1'b1;
          end
        end else if (ack) begin
          m_valid[k] = 1'b0;
        end
        m_pend[k] = (m_pend[k] & ~clr) | set;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; x = 8'h00; ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; x = 8'hFF; ack = 1'b0;
    step(); step();
    tests++;
    if (pend_hi !== 8'h00 || valid_hi !== 1'b0 || o_hi !== 3'd0 || lost_hi !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: pend=%h valid=%b o=%0d lost=%b, required 00 0 0 0",
               pend_hi, valid_hi, o_hi, lost_hi);
    end
    rst = 1'b0;
    step();
    tests++;
    if (valid_hi !== 1'b0 || pend_hi !== 8'hFF) begin
      failed++;
      $display("FAIL reset_release_1: valid=%b pend=%h, required 0 ff", valid_hi, pend_hi);
    end
    step();
    tests++;
    if (valid_hi !== 1'b1 || o_hi !== 3'd7 || valid_lo !== 1'b1 || o_lo !== 3'd0) begin
      failed++;
      $display("FAIL reset_release_2: hi v=%b o=%0d lo v=%b o=%0d, required 1 7 1 0",
               valid_hi, o_hi, valid_lo, o_lo);
    end
  endtask

  task automatic test_priority_drain();
    logic [2:0] seq_hi[$], seq_lo[$];
    logic prev_hi;
    int bubble_err;
    do_reset();
    en = 1'b1; ack = 1'b1; x = 8'b1010_0100;
    step();
    x = 8'h00;
    prev_hi = 1'b0;
    bubble_err = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (valid_hi) seq_hi.push_back(o_hi);
      if (valid_lo) seq_lo.push_back(o_lo);
      if (valid_hi && prev_hi) bubble_err++;
      prev_hi = valid_hi;
    end
    tests++;
    if (seq_hi.size() != 3 || seq_hi[0] !== 3'd7 || seq_hi[1] !== 3'd5 || seq_hi[2] !== 3'd2) begin
      failed++;
      $display("FAIL drain_high: got %p, required 7 5 2", seq_hi);
    end
    tests++;
    if (seq_lo.size() != 3 || seq_lo[0] !== 3'd2 || seq_lo[1] !== 3'd5 || seq_lo[2] !== 3'd7) begin
      failed++;
      $display("FAIL drain_low: got %p, required 2 5 7", seq_lo);
    end
    tests++;
    if (bubble_err != 0) begin
      failed++;
      $display("FAIL drain_bubble: %0d back-to-back valid cycles, required 0", bubble_err);
    end
    tests++;
    if (pend_hi !== 8'h00 || lost_hi !== 1'b0 || pend_lo !== 8'h00 || lost_lo !== 1'b0) begin
      failed++;
      $display("FAIL drain_end: pend=%h/%h lost=%b/%b, required 00/00 0/0",
               pend_hi, pend_lo, lost_hi, lost_lo);
    end
  endtask

  task automatic test_hold_no_preempt();
    do_reset();
    en = 1'b1; ack = 1'b0; x = 8'h01;
    step();
    x = 8'h00;
    step();
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (valid_hi !== 1'b1 || o_hi !== 3'd0) begin
        failed++;
        $display("FAIL hold_c%0d: valid=%b o=%0d, required 1 0", c, valid_hi, o_hi);
      end
      step();
    end
    x = 8'h80;
    step();
    x = 8'h00;
    step();
    tests++;
    if (valid_hi !== 1'b1 || o_hi !== 3'd0 || pend_hi !== 8'h81) begin
      failed++;
      $display("FAIL no_preempt: valid=%b o=%0d pend=%h, required 1 0 81", valid_hi, o_hi, pend_hi);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests++;
    if (valid_hi !== 1'b0 || pend_hi !== 8'h80) begin
      failed++;
      $display("FAIL hold_bubble: valid=%b pend=%h, required 0 80", valid_hi, pend_hi);
    end
    step();
    tests++;
    if (valid_hi !== 1'b1 || o_hi !== 3'd7 || valid_lo !== 1'b1 || o_lo !== 3'd7) begin
      failed++;
      $display("FAIL hold_next: hi v=%b o=%0d lo v=%b o=%0d, required 1 7 1 7",
               valid_hi, o_hi, valid_lo, o_lo);
    end
  endtask

  task automatic test_set_and_retire();
    do_reset();
    en = 1'b1; ack = 1'b0; x = 8'h08;
    step();
    x = 8'h00;
    step();
    tests++;
    if (valid_hi !== 1'b1 || o_hi !== 3'd3) begin
      failed++;
      $display("FAIL sar_present: valid=%b o=%0d, required 1 3", valid_hi, o_hi);
    end
    ack = 1'b1; x = 8'h08;
    step();
    ack = 1'b0; x = 8'h00;
    tests++;
    if (pend_hi !== 8'h08 || lost_hi !== 1'b0 || valid_hi !== 1'b0) begin
      failed++;
      $display("FAIL sar_setwins: pend=%h lost=%b valid=%b, required 08 0 0",
               pend_hi, lost_hi, valid_hi);
    end
    step();
    tests++;
    if (valid_hi !== 1'b1 || o_hi !== 3'd3) begin
      failed++;
      $display("FAIL sar_again: valid=%b o=%0d, required 1 3", valid_hi, o_hi);
    end
  endtask

  task automatic test_lost_en();
    do_reset();
    en = 1'b1; ack = 1'b0; x = 8'h10;
    step();
    x = 8'h00;
    step();
    en = 1'b0; x = 8'hFF;
    step();
    x = 8'h00; en = 1'b1;
    tests++;
    if (pend_hi !== 8'h10 || lost_hi !== 1'b0) begin
      failed++;
      $display("FAIL en_gate: pend=%h lost=%b, required 10 0", pend_hi, lost_hi);
    end
    x = 8'h10;
    step();
    x = 8'h00;
    tests++;
    if (lost_hi !== 1'b1 || lost_lo !== 1'b1) begin
      failed++;
      $display("FAIL lost_set: lost=%b/%b, required 1/1", lost_hi, lost_lo);
    end
    ack = 1'b1;
    step(); step(); step();
    ack = 1'b0;
    en = 1'b0; x = 8'hFF;
    step();
    en = 1'b1; x = 8'h00;
    tests++;
    if (lost_hi !== 1'b1 || pend_hi !== 8'h00) begin
      failed++;
      $display("FAIL lost_sticky: lost=%b pend=%h, required 1 00", lost_hi, pend_hi);
    end
    do_reset();
    tests++;
    if (lost_hi !== 1'b0) begin
      failed++;
      $display("FAIL lost_clear: lost=%b, required 0", lost_hi);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      x   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ack = ($urandom_range(0, 2) != 0);
      step();
      tests++;
      if (o_hi !== m_o[1] || valid_hi !== m_valid[1] || pend_hi !== m_pend[1] || lost_hi !== m_lost[1]) begin
        failed++;
        $display("FAIL rand_hi_c%0d: o=%0d v=%b p=%h l=%b, required o=%0d v=%b p=%h l=%b",
                 c, o_hi, valid_hi, pend_hi, lost_hi, m_o[1], m_valid[1], m_pend[1], m_lost[1]);
      end
      tests++;
      if (o_lo !== m_o[0] || valid_lo !== m_valid[0] || pend_lo !== m_pend[0] || lost_lo !== m_lost[0]) begin
        failed++;
        $display("FAIL rand_lo_c%0d: o=%0d v=%b p=%h l=%b, required o=%0d v=%b p=%h l=%b",
                 c, o_lo, valid_lo, pend_lo, lost_lo, m_o[0], m_valid[0], m_pend[0], m_lost[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_o[k] = 3'd0; m_valid[k] = 1'b0; m_lost[k] = 1'b0;
    end
    #1;
    test_reset();
    test_priority_drain();
    test_hold_no_preempt();
    test_set_and_retire();
    test_lost_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/eight_three_priority_encoder.md
# eight_three_priority_encoder

Sequential 8-to-3 priority encoder, the encoding counterpart of the team's 3-to-8 decoder. It accumulates up to eight independent request lines into a pending register and presents the index of the highest-priority pending request as a 3-bit code. Each code is held stable under a valid/ack handshake. On ack, that request is retired and the next pending one is presented. It sits on the request side of decoder-driven select logic: a code taken from O can be fed straight into the decoder's X input.

## Interface
- PRIO_HIGH, default 1: 1 = index 7 has highest priority; 0 = index 0 has highest priority.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- En  input  1  capture enable; when 0, X is ignored but draining continues.
- X  input  8  request lines; sampled every clk edge while En=1; multi-hot allowed.
- Ack  input  1  consumer accepts the current code; meaningful only while Valid=1.
- O  output  3  encoded index of the presented request (registered).
- Valid  output  1  O holds a pending request (registered).
- Pend  output  8  current pending register (registered).
- Lost  output  1  sticky flag: a request arrived on an already-pending, not-retiring bit.

## Operation
- Reset (rst=1 at an edge): Pend=8'h00, O=3'd0, Valid=0, Lost=0, state=IDLE. Reset overrides every other input, including mid-handshake.
- Pending update at every edge: Pend <= (Pend & ~clr) | (En ? X : 8'h00).
  - clr is one-hot at index O when Valid=1 and Ack=1; otherwise clr=0.
  - Set wins: if X sets the bit being retired in the same cycle, the bit stays pending. This is not a loss.
- Lost is set when En=1, X[i]=1, Pend[i]=1 and bit i is not cleared this cycle. Lost is cleared only by rst.
- Two-state FSM:
  - IDLE: Valid=0. If Pend≠0 at the edge, O <= index of the highest-priority set bit of the current Pend, Valid <= 1, go to PRESENT. Otherwise stay in IDLE with O unchanged.
  - PRESENT: Valid=1 and O is held stable regardless of X, En or Pend changes. If Ack=1, clear Pend[O], Valid <= 0, go to IDLE. If Ack=0, stay in PRESENT.
- Priority is evaluated only at the IDLE→PRESENT transition. A higher-priority request arriving while in PRESENT does not preempt; it is served next.
- Ack while Valid=0 is ignored and has no effect on Pend.
- O keeps its last value after retirement (Valid=0); consumers must qualify O with Valid.

## Timing
- Capture latency: X high at edge t → Pend bit set after edge t → Valid=1 with O valid after edge t+1, if IDLE and that bit has the highest priority.
- Handshake: transfer occurs at an edge where Valid=1 and Ack=1. Valid drops after that edge.
- One mandatory bubble cycle follows each transfer. Peak throughput is one code per 2 cycles; 8 simultaneous requests fully drain in 16 cycles with Ack held high.
- Ack held permanently high is legal and gives the peak rate.
- Pend shows the register value, so a retired bit reads 0 from the cycle after the transfer edge.
- Wrap/full: Pend=8'hFF is legal. Further requests on pending bits set Lost; nothing else changes.

## Test plan
- Reset: drive rst=1 with X=8'hFF, En=1 for 2 cycles → Pend=0, Valid=0, O=0, Lost=0. Release rst → Valid=1 with O=7 exactly 2 edges later.
- Priority drain (PRIO_HIGH=1): pulse X=8'b1010_0100 for one cycle, Ack tied 1 → O sequence 7, 5, 2, each with Valid high for one cycle and separated by one Valid=0 bubble. Pend ends at 0 and Lost=0.
- Priority reversed (PRIO_HIGH=0): same stimulus → O sequence 2, 5, 7.
- Hold and no preempt: X=8'h01 with Ack=0 → O=0 held 5 cycles. Then pulse X=8'h80 → O stays 0 until Ack. After the Ack edge and the bubble cycle, O=7.
- Simultaneous set and retire: Valid=1, O=3, assert Ack=1 and X=8'h08 in the same cycle → Pend[3] stays 1, Lost=0, and O=3 is presented again after the bubble.
- Lost and En gating:
  - With Pend[4]=1 and not retiring, pulse X=8'h10 → Lost=1, stays 1 until rst.
  - With En=0, pulse X=8'hFF → Pend unchanged and Lost unchanged.
